// File: rtl/dmi_pkg.sv
// Shared DMI definitions: request/response codes, DM register map and the
// master state encoding used by the Wishbone DMI master.
package dmi_pkg;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_SUCCESS  = 2'd0,
    DMI_RSP_RSVD = 2'd1,
    DMI_FAILED   = 2'd2,
    DMI_BUSY     = 2'd3
  } dmi_rsp_e;

  localparam logic [31:0] ADDRESS_DM_CONTROL_REGISTER = 32'h10;
  localparam int unsigned HALTREQ   = 31;
  localparam int unsigned RESUMEREQ = 30;
  localparam int unsigned HARTRESET = 29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RELEASE,
    ST_RESP
  } master_state_e;

  // Timeout counter width: enough to hold the terminal count, never below 8 bits.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    int unsigned w;
    w = $clog2(terminal + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter bounding a Wishbone cycle; tc_o flags the terminal count.
module wb_timeout_counter #(
  parameter int unsigned TERMINAL = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/wishbone_dmi_master.sv
// Turns single DMI requests from the DTM into single Wishbone classic cycles
// towards the DM slave and returns one DMI response per request.
module wishbone_dmi_master
  import dmi_pkg::*;
#(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_op_o,
  output logic [31:0]       rsp_data_o,
  output logic [31:0]       addr_o,
  output logic              we_o,
  output logic [63:0]       data_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic [63:0]       data_i,
  input  logic              ack_i
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  master_state_e     state_q, state_d;
  dmi_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  dmi_rsp_e          rsp_op_q, rsp_op_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  // Only the low word of the 64-bit bus carries DMI data.
  logic unused_data_hi;
  assign unused_data_hi = ^data_i[63:32];

  wb_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES),
    .CNT_W    (CNT_W)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    cyc_o       = 1'b0;
    we_o        = 1'b0;
    cnt_clr     = (state_q != ST_BUS);
    cnt_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d       = dmi_op_e'(req_op_i);
          addr_d     = req_addr_i;
          wdata_d    = req_data_i;
          rsp_data_d = '0;
          unique case (dmi_op_e'(req_op_i))
            DMI_READ, DMI_WRITE: begin
              rsp_op_d = DMI_SUCCESS;
              state_d  = ST_BUS;
            end
            DMI_NOP: begin
              rsp_op_d = DMI_SUCCESS;
              state_d  = ST_RESP;
            end
            default: begin
              rsp_op_d = DMI_FAILED;
              state_d  = ST_RESP;
            end
          endcase
        end
      end

      ST_BUS: begin
        cyc_o  = 1'b1;
        we_o   = (op_q == DMI_WRITE);
        cnt_en = 1'b1;
        // ack is checked first so a late ack on the terminal cycle still succeeds.
        if (ack_i) begin
          rsp_op_d = DMI_SUCCESS;
          if (op_q == DMI_READ) begin
            rsp_data_d = data_i[31:0];
          end
          state_d = ST_RELEASE;
        end else if (cnt_tc) begin
          rsp_op_d   = DMI_FAILED;
          rsp_data_d = '0;
          state_d    = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!ack_i) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= DMI_NOP;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_op_q   <= DMI_SUCCESS;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_op_q   <= rsp_op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign stb_o      = cyc_o;
  assign addr_o     = 32'(addr_q);
  assign data_o     = {32'h0, wdata_q};
  assign rsp_op_o   = (state_q == ST_RESP) ? rsp_op_q : 2'b00;
  assign rsp_data_o = (state_q == ST_RESP) ? rsp_data_q : 32'h0;

endmodule

// File: tb/tb_wishbone_dmi_master.sv
// Directed bench for wishbone_dmi_master with a one-register DM slave model.
module tb_wishbone_dmi_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready_o;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [1:0]  rsp_op_o;
  logic [31:0] rsp_data_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic [63:0] data_o;
  logic        cyc_o;
  logic        stb_o;
  logic [63:0] data_i;
  logic        ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  wishbone_dmi_master #(
    .ADDR_W         (7),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .rsp_op_o    (rsp_op_o),
    .rsp_data_o  (rsp_data_o),
    .addr_o      (addr_o),
    .we_o        (we_o),
    .data_o      (data_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .data_i      (data_i),
    .ack_i       (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DM slave: combinational ack held while cyc/stb high, upper read word is junk.
  logic [31:0] dmcontrol;
  logic        dead;
  assign ack_i  = cyc_o & stb_o & ~dead;
  assign data_i = {32'hDEAD_BEEF, dmcontrol};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dmcontrol <= 32'h0;
    else if (cyc_o && stb_o && we_o && ack_i && addr_o == 32'h10) dmcontrol <= data_o[31:0];
  end

  // Shortest run of cyc_o low between two cycles.
  int  low_run = 0;
  int  min_gap = 1000;
  bit  seen_cyc = 0;
  logic prev_mon = 1'b0;
  always @(negedge clk) begin
    if (cyc_o) begin
      if (!prev_mon && seen_cyc && low_run < min_gap) min_gap = low_run;
      seen_cyc = 1;
      low_run  = 0;
    end else begin
      low_run++;
    end
    prev_mon = cyc_o;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [1:0]  t_rop;
  logic [31:0] t_rdata;
  logic [31:0] t_addr_seen;
  logic [63:0] t_wdata_seen;
  int          t_cyc_n, t_pulses, t_ready_hi, t_first_cyc, t_first_rsp;
  bit          t_we_hi, t_ok;

  task automatic run_txn(input logic [1:0] op, input logic [6:0] addr,
                         input logic [31:0] wdata, input int hold);
    int   idx, vcnt;
    bit   done;
    logic prev;
    t_rop = 2'bxx; t_rdata = 'x; t_addr_seen = '0; t_wdata_seen = '0;
    t_cyc_n = 0; t_pulses = 0; t_ready_hi = 0; t_first_cyc = -1; t_first_rsp = -1;
    t_we_hi = 0; t_ok = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = wdata;
    rsp_ready = (hold == 0);
    for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
    check_eq("accept_ready", {63'h0, req_ready_o}, 64'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    idx = 0; vcnt = 0; done = 0; prev = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      idx++;
      if (cyc_o) begin
        t_cyc_n++;
        if (t_first_cyc < 0) t_first_cyc = idx;
        if (we_o) t_we_hi = 1;
        t_addr_seen  = addr_o;
        t_wdata_seen = data_o;
      end
      if (cyc_o && !prev) t_pulses++;
      prev = cyc_o;
      if (req_ready_o) t_ready_hi++;
      if (rsp_valid_o) begin
        if (t_first_rsp < 0) t_first_rsp = idx;
        if (vcnt >= hold) begin
          rsp_ready = 1'b1;
          t_rop     = rsp_op_o;
          t_rdata   = rsp_data_o;
          done      = 1;
        end else begin
          vcnt++;
        end
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    t_ok = done;
    check_eq("rsp_seen", {63'h0, t_ok}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; dead = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", {63'h0, req_ready_o}, 64'h1);
    check_eq("rst_cyc", {62'h0, cyc_o, stb_o}, 64'h0);
    check_eq("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
    check_eq("rst_we", {63'h0, we_o}, 64'h0);
    check_eq("rst_addr", {32'h0, addr_o}, 64'h0);
    check_eq("rst_data", data_o, 64'h0);
    check_eq("rst_rsp", {30'h0, rsp_op_o, rsp_data_o}, 64'h0);

    // Write dmcontrol.haltreq
    run_txn(2'd2, 7'h10, 32'h8000_0000, 0);
    check_eq("wr_rsp_op", {62'h0, t_rop}, 64'h0);
    check_eq("wr_rsp_data", {32'h0, t_rdata}, 64'h0);
    check_eq("wr_pulses", 64'(t_pulses), 64'd1);
    check_eq("wr_cyc_len", 64'(t_cyc_n), 64'd1);
    check_eq("wr_we", {63'h0, t_we_hi}, 64'h1);
    check_eq("wr_addr", {32'h0, t_addr_seen}, 64'h10);
    check_eq("wr_data_o", t_wdata_seen, 64'h8000_0000);
    check_eq("wr_lat_cyc", 64'(t_first_cyc), 64'd1);
    check_eq("wr_lat_rsp", 64'(t_first_rsp), 64'd3);
    check_eq("wr_slave_reg", {32'h0, dmcontrol}, 64'h8000_0000);
    @(negedge clk);
    check_eq("wr_back_idle", {62'h0, req_ready_o, rsp_valid_o}, 64'h2);

    // Read it back; upper data_i word must be ignored
    run_txn(2'd1, 7'h10, 32'h0, 0);
    check_eq("rd_rsp_op", {62'h0, t_rop}, 64'h0);
    check_eq("rd_rsp_data", {32'h0, t_rdata}, 64'h8000_0000);
    check_eq("rd_we", {63'h0, t_we_hi}, 64'h0);
    check_eq("rd_pulses", 64'(t_pulses), 64'd1);

    // Timeout with dead slave: TIMEOUT_CYCLES=4 -> 5 BUS cycles
    dead = 1'b1;
    run_txn(2'd1, 7'h10, 32'h0, 0);
    check_eq("to_cyc_len", 64'(t_cyc_n), 64'd5);
    check_eq("to_pulses", 64'(t_pulses), 64'd1);
    check_eq("to_rsp_op", {62'h0, t_rop}, 64'h2);
    check_eq("to_rsp_data", {32'h0, t_rdata}, 64'h0);
    dead = 1'b0;

    // NOP and reserved op never touch the bus
    run_txn(2'd0, 7'h10, 32'h1234_5678, 0);
    check_eq("nop_rsp_op", {62'h0, t_rop}, 64'h0);
    check_eq("nop_cyc", 64'(t_cyc_n), 64'd0);
    check_eq("nop_lat_rsp", 64'(t_first_rsp), 64'd1);
    run_txn(2'd3, 7'h10, 32'h1234_5678, 0);
    check_eq("rsv_rsp_op", {62'h0, t_rop}, 64'h2);
    check_eq("rsv_cyc", 64'(t_cyc_n), 64'd0);
    check_eq("rsv_rsp_data", {32'h0, t_rdata}, 64'h0);
    check_eq("rsv_slave_reg", {32'h0, dmcontrol}, 64'h8000_0000);

    // Back-to-back writes with response backpressure
    run_txn(2'd2, 7'h10, 32'h1, 5);
    check_eq("b2b1_rsp_op", {62'h0, t_rop}, 64'h0);
    check_eq("b2b1_ready_low", 64'(t_ready_hi), 64'd0);
    check_eq("b2b1_held", 64'(t_first_rsp), 64'd3);
    run_txn(2'd2, 7'h10, 32'h2, 5);
    check_eq("b2b2_rsp_op", {62'h0, t_rop}, 64'h0);
    check_eq("b2b2_ready_low", 64'(t_ready_hi), 64'd0);
    check_eq("b2b_slave_reg", {32'h0, dmcontrol}, 64'h2);
    check_eq("b2b_min_gap_ok", {63'h0, (min_gap >= 1)}, 64'h1);
    run_txn(2'd1, 7'h10, 32'h0, 0);
    check_eq("b2b_readback", {32'h0, t_rdata}, 64'h2);

    // Asynchronous reset while a cycle is on the bus
    dead = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h10;
    for (int i = 0; i < 10 && !cyc_o; i++) @(negedge clk);
    req_valid = 1'b0;
    check_eq("mid_cyc_up", {63'h0, cyc_o}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_cyc_drop", {62'h0, cyc_o, stb_o}, 64'h0);
    check_eq("mid_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dead  = 1'b0;
    @(negedge clk);
    check_eq("mid_ready_after", {63'h0, req_ready_o}, 64'h1);
    check_eq("mid_idle_after", {62'h0, cyc_o, rsp_valid_o}, 64'h0);
    run_txn(2'd2, 7'h10, 32'h2A, 0);
    check_eq("post_rst_rsp_op", {62'h0, t_rop}, 64'h0);
    check_eq("post_rst_reg", {32'h0, dmcontrol}, 64'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
